jedro_1_ifu: RTL and testbench

Instruction fetch unit for the jedro_1 RV32I core. Issues word fetches to instruction memory over a request/grant/rvalid bus, buffers returned words in a 2-entry prefetch FIFO, and presents them with their addresses to the decoder over a valid/ready handshake. Handles redirects (jumps/branches) from the control unit by flushing the buffer and discarding in-flight responses.

---
 rtl/jedro_1_ifu_pkg.sv | 19 +
 rtl/jedro_1_ifu_fifo.sv | 54 +++++
 rtl/jedro_1_ifu.sv | 132 +++++++++++++
 tb/tb_jedro_1_ifu.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jedro_1_ifu_pkg.sv
// Shared constants and types for the jedro_1 instruction fetch unit.
// Defines data width, prefetch depth, boot address default, IFU states and the {addr,data} entry.
package jedro_1_ifu_pkg;

  localparam int          DATA_WIDTH        = 32;
  localparam int          FIFO_DEPTH        = 2;
  localparam logic [31:0] DEFAULT_BOOT_ADDR = 32'h0000_0000;

  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } ifu_state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/jedro_1_ifu_fifo.sv
// Two-entry prefetch buffer of {addr,data}; push lands next edge, head read straight from storage.
// No internal backpressure: the caller's credit accounting guarantees a push never meets a full buffer.
module jedro_1_ifu_fifo
  import jedro_1_ifu_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic [1:0]   count
);

  fetch_entry_t mem [FIFO_DEPTH];
  logic         wptr;
  logic         rptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wptr   <= 1'b0;
      rptr   <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        mem[wptr] <= wdata;
        wptr      <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rptr];

  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      assert (!(push && !pop && count == 2'(FIFO_DEPTH)));
      assert (!(pop && count == 2'd0));
    end
  end

endmodule

// File: rtl/jedro_1_ifu.sv
// jedro_1 fetch unit: credit-limited word fetch into a 2-entry prefetch buffer; rvalid to instr_valid_o is 1 cycle.
// Redirects flush the buffer and drop in-flight words; JEDRO_1_IFU_MISALIGN_TRAP_EN adds a misaligned-target trap.
module jedro_1_ifu
  import jedro_1_ifu_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR = DEFAULT_BOOT_ADDR
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  input  logic                  jmp_instr_i,
  input  logic [DATA_WIDTH-1:0] jmp_addr_i,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [DATA_WIDTH-1:0] instr_rdata_o,
  output logic [DATA_WIDTH-1:0] instr_addr_o
`ifdef JEDRO_1_IFU_MISALIGN_TRAP_EN
  ,output logic                 misaligned_o
`endif
);

  ifu_state_e            state, state_n;
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] tgt;
  logic [DATA_WIDTH-1:0] rsp_pc;
  logic [DATA_WIDTH-1:0] jmp_tgt;
  logic                  pend;
  logic                  jmp_pend;
  logic                  jmp_misaligned;
  logic [1:0]            outstanding, out_n;
  logic [1:0]            discard, discard_n;
  logic [1:0]            fifo_count;
  logic [2:0]            in_use;
  logic                  gnt, rsp_ok, push, pop, req_new;
  fetch_entry_t          wentry, head;

  assign jmp_tgt = jmp_addr_i & 32'hFFFF_FFFC;
`ifdef JEDRO_1_IFU_MISALIGN_TRAP_EN
  assign jmp_misaligned = jmp_addr_i[1:0] != 2'b00;
  assign misaligned_o   = state == TRAP;
`else
  assign jmp_misaligned = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= RUN;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (jmp_instr_i) state_n = jmp_misaligned ? TRAP : RUN;
  end

  // A word being consumed this cycle already frees its slot, which keeps zero-wait memory at full rate.
  assign pop     = instr_valid_o && instr_ready_i && !jmp_instr_i;
  assign in_use  = {1'b0, fifo_count} + {1'b0, outstanding} - {2'b00, pop};
  assign req_new = (state == RUN) && !jmp_pend && (in_use < 3'd2);

  assign imem_req_o  = !rst_i && (pend || req_new);
  assign imem_addr_o = pc;
  assign gnt         = imem_req_o && imem_gnt_i;

  // Stray responses (nothing outstanding) and stale ones (discard pending) never reach the buffer.
  assign rsp_ok = imem_rvalid_i && (discard == 2'd0) && (outstanding != 2'd0);
  assign push   = rsp_ok && !jmp_instr_i;
  assign out_n  = outstanding + {1'b0, gnt} - {1'b0, imem_rvalid_i && (outstanding != 2'd0)};

  always_comb begin
    discard_n = discard;
    if (jmp_instr_i) begin
      discard_n = out_n;
    end else begin
      if (imem_rvalid_i && discard != 2'd0) discard_n = discard_n - 2'd1;
      if (gnt && jmp_pend)                  discard_n = discard_n + 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc          <= BOOT_ADDR;
      tgt         <= BOOT_ADDR;
      rsp_pc      <= BOOT_ADDR;
      pend        <= 1'b0;
      jmp_pend    <= 1'b0;
      outstanding <= 2'd0;
      discard     <= 2'd0;
    end else begin
      outstanding <= out_n;
      discard     <= discard_n;
      pend        <= imem_req_o && !imem_gnt_i;
      // An ungranted request must stay on the bus; the redirect target waits in tgt until it is granted.
      if (jmp_instr_i && imem_req_o && !imem_gnt_i) begin
        jmp_pend <= 1'b1;
        tgt      <= jmp_tgt;
      end else if (jmp_instr_i) begin
        pc       <= jmp_tgt;
        jmp_pend <= 1'b0;
      end else if (gnt && jmp_pend) begin
        pc       <= tgt;
        jmp_pend <= 1'b0;
      end else if (gnt) begin
        pc <= pc + 32'd4;
      end
      if (jmp_instr_i) rsp_pc <= jmp_tgt;
      else if (push)   rsp_pc <= rsp_pc + 32'd4;
    end
  end

  assign wentry.addr = rsp_pc;
  assign wentry.data = imem_rdata_i;

  jedro_1_ifu_fifo u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .pop   (pop),
    .flush (jmp_instr_i),
    .wdata (wentry),
    .rdata (head),
    .count (fifo_count)
  );

  assign instr_valid_o = (fifo_count != 2'd0) && (state == RUN);
  assign instr_rdata_o = head.data;
  assign instr_addr_o  = head.addr;

endmodule

// File: tb/tb_jedro_1_ifu.sv
// Directed bench for jedro_1_ifu with an in-order memory model of configurable grant and latency.
module tb_jedro_1_ifu;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        jmp_instr_i = 1'b0;
  logic [31:0] jmp_addr_i = '0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic [31:0] instr_rdata_o;
  logic [31:0] instr_addr_o;
`ifdef JEDRO_1_IFU_MISALIGN_TRAP_EN
  logic        misaligned_o;
`endif

  int errors = 0;
  int checks = 0;

  logic gnt_en = 1'b1;
  int   lat    = 1;
  logic stray  = 1'b0;
  int   mcyc   = 0;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } rsp_t;
  rsp_t q[$];

  jedro_1_ifu dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .jmp_instr_i   (jmp_instr_i),
    .jmp_addr_i    (jmp_addr_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_rdata_o (instr_rdata_o),
    .instr_addr_o  (instr_addr_o)
`ifdef JEDRO_1_IFU_MISALIGN_TRAP_EN
    ,.misaligned_o (misaligned_o)
`endif
  );

  initial forever #5 clk_i = ~clk_i;

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'h0000_0013 ^ (a << 8);
  endfunction

  // Memory: decides grant/rvalid 2 time units after each rising edge, once the bench inputs have settled.
  initial begin
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    forever begin
      @(posedge clk_i);
      #2;
      mcyc++;
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = '0;
      if (rst_i) begin
        q.delete();
        imem_gnt_i = 1'b0;
      end else begin
        if (stray) begin
          imem_rvalid_i = 1'b1;
          imem_rdata_i  = 32'hDEAD_BEEF;
          stray         = 1'b0;
        end else if (q.size() > 0 && q[0].due <= mcyc) begin
          imem_rvalid_i = 1'b1;
          imem_rdata_i  = word(q[0].addr);
          void'(q.pop_front());
        end
        imem_gnt_i = gnt_en && imem_req_o;
        if (imem_gnt_i) q.push_back('{due: mcyc + lat, addr: imem_addr_o});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i         = 1'b1;
    jmp_instr_i   = 1'b0;
    instr_ready_i = 1'b0;
    gnt_en        = 1'b1;
    lat           = 1;
    repeat (3) adv();
  endtask

  task automatic wait_valid(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      adv();
      #4;
      if (instr_valid_o) break;
    end
    chk(tag, 32'(instr_valid_o), 32'd1);
  endtask

  initial begin
    // Reset values
    do_reset();
    #4;
    chk("rst_req", 32'(imem_req_o), 32'd0);
    chk("rst_addr", imem_addr_o, 32'h0);
    chk("rst_valid", 32'(instr_valid_o), 32'd0);
    chk("rst_rdata", instr_rdata_o, 32'h0);
    chk("rst_iaddr", instr_addr_o, 32'h0);
`ifdef JEDRO_1_IFU_MISALIGN_TRAP_EN
    chk("rst_misaligned", 32'(misaligned_o), 32'd0);
`endif

    // Zero-wait streaming; a stray rvalid right after reset must be ignored
    adv(); rst_i = 1'b0; instr_ready_i = 1'b1; stray = 1'b1; #4;
    chk("boot_req", 32'(imem_req_o), 32'd1);
    chk("boot_addr", imem_addr_o, 32'h0);
    adv(); #4;
    chk("c1_valid", 32'(instr_valid_o), 32'd0);
    chk("c1_addr", imem_addr_o, 32'h4);
    for (int i = 0; i < 4; i++) begin
      adv(); #4;
      chk("stream_valid", 32'(instr_valid_o), 32'd1);
      chk("stream_iaddr", instr_addr_o, 32'(4 * i));
      chk("stream_rdata", instr_rdata_o, word(32'(4 * i)));
    end

    // Decoder stall: buffer fills to two words, requests stop
    adv(); instr_ready_i = 1'b0; #4;
    chk("stall_req0", 32'(imem_req_o), 32'd0);
    for (int i = 0; i < 9; i++) begin
      adv(); #4;
      chk("stall_req", 32'(imem_req_o), 32'd0);
    end
    chk("stall_valid", 32'(instr_valid_o), 32'd1);
    chk("stall_head", instr_addr_o, 32'h10);
    adv(); instr_ready_i = 1'b1; #4;
    chk("resume_req", 32'(imem_req_o), 32'd1);
    chk("resume_addr", imem_addr_o, 32'h18);
    chk("resume_head", instr_addr_o, 32'h10);
    adv(); #4;
    chk("resume_head1", instr_addr_o, 32'h14);
    adv(); #4;
    chk("resume_head2", instr_addr_o, 32'h18);
    chk("resume_rdata2", instr_rdata_o, word(32'h18));

    // 3-cycle latency, redirect with two responses in flight
    do_reset();
    adv(); rst_i = 1'b0; lat = 3; instr_ready_i = 1'b1; #4;
    adv(); #4;
    adv(); jmp_instr_i = 1'b1; jmp_addr_i = 32'h100; #4;
    chk("lat_credit_req", 32'(imem_req_o), 32'd0);
    adv(); jmp_instr_i = 1'b0; #4;
    chk("lat_jmp_valid", 32'(instr_valid_o), 32'd0);
    wait_valid("lat_wait", 20);
    chk("lat_first_iaddr", instr_addr_o, 32'h100);
    chk("lat_first_rdata", instr_rdata_o, word(32'h100));
    adv(); #4;
    chk("lat_next_valid", 32'(instr_valid_o), 32'd1);
    chk("lat_next_iaddr", instr_addr_o, 32'h104);

    // Ungranted request at 0x8 across a redirect to 0x40; jump and ready coincide with head at 0x4
    do_reset();
    adv(); rst_i = 1'b0; instr_ready_i = 1'b1; #4;
    adv(); #4;
    adv(); gnt_en = 1'b0; #4;
    chk("pend_req", 32'(imem_req_o), 32'd1);
    chk("pend_addr", imem_addr_o, 32'h8);
    adv(); jmp_instr_i = 1'b1; jmp_addr_i = 32'h40; #4;
    chk("jr_head_valid", 32'(instr_valid_o), 32'd1);
    chk("jr_head_addr", instr_addr_o, 32'h4);
    chk("jr_addr", imem_addr_o, 32'h8);
    adv(); jmp_instr_i = 1'b0; #4;
    chk("jr_valid_after", 32'(instr_valid_o), 32'd0);
    chk("hold_req", 32'(imem_req_o), 32'd1);
    chk("hold_addr", imem_addr_o, 32'h8);
    adv(); #4;
    chk("hold_addr2", imem_addr_o, 32'h8);
    adv(); gnt_en = 1'b1; #4;
    chk("gnt_addr", imem_addr_o, 32'h8);
    adv(); #4;
    chk("tgt_req", 32'(imem_req_o), 32'd1);
    chk("tgt_addr", imem_addr_o, 32'h40);
    wait_valid("tgt_wait", 20);
    chk("tgt_iaddr", instr_addr_o, 32'h40);
    chk("tgt_rdata", instr_rdata_o, word(32'h40));

    // Misaligned redirect
    do_reset();
    adv(); rst_i = 1'b0; instr_ready_i = 1'b1; #4;
    adv(); #4;
    adv(); jmp_instr_i = 1'b1; jmp_addr_i = 32'h102; #4;
`ifdef JEDRO_1_IFU_MISALIGN_TRAP_EN
    adv(); jmp_instr_i = 1'b0; #4;
    chk("trap_mis", 32'(misaligned_o), 32'd1);
    chk("trap_valid", 32'(instr_valid_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("trap_req", 32'(imem_req_o), 32'd0);
      adv(); #4;
    end
    adv(); jmp_instr_i = 1'b1; jmp_addr_i = 32'h200; #4;
    chk("trap_exit_mis_j", 32'(misaligned_o), 32'd1);
    chk("trap_exit_req_j", 32'(imem_req_o), 32'd0);
    adv(); jmp_instr_i = 1'b0; #4;
    chk("trap_exit_mis", 32'(misaligned_o), 32'd0);
    chk("trap_exit_req", 32'(imem_req_o), 32'd1);
    chk("trap_exit_addr", imem_addr_o, 32'h200);
    wait_valid("trap_exit_wait", 20);
    chk("trap_exit_iaddr", instr_addr_o, 32'h200);
`else
    adv(); jmp_instr_i = 1'b0; #4;
    chk("align_req", 32'(imem_req_o), 32'd1);
    chk("align_addr", imem_addr_o, 32'h100);
    wait_valid("align_wait", 20);
    chk("align_iaddr", instr_addr_o, 32'h100);
    chk("align_rdata", instr_rdata_o, word(32'h100));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
